binary_to_bcd_converter: RTL
============================

Name: binary_to_bcd_converter

Overview:
Converts an unsigned binary value into packed BCD digits for the multiplexed seven-segment controller. It uses a sequential double-dabble (shift-and-add-3) engine, one bit per clock. The `data` output connects directly to the controller's `data` input. A start/busy/done handshake lets a host FSM or counter request a new display value.

Parameters:
- INPUT_WIDTH, 27, width of the binary input. The default covers 0..99,999,999. Legal range is 1..32.
- NUM_DIGITS, 8, number of BCD digits produced. Must equal the controller's NUM_DIGITS. Legal range is 1..8.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- start  in  1  conversion request. Sampled only in IDLE.
- binary  in  INPUT_WIDTH  unsigned value. Captured on the edge that accepts start.
- busy  out  1  high while a conversion is in progress (SHIFT or DONE state).
- done  out  1  one-cycle pulse; data/overflow valid and updated.
- overflow  out  1  last conversion exceeded 10^NUM_DIGITS - 1.
- data  out  NUM_DIGITS*4  packed BCD. Digit 0 is bits [3:0] and is the least significant. Held between conversions.

Behaviour:
- One clock domain (clock). resetN is asynchronous assert. All flops clear immediately when resetN is low.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, overflow = 0
  - data = 0
  - internal shift/BCD scratch and bit counter = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: capture binary into the shift register, clear BCD scratch, clear sticky overflow scratch, counter = 0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one bit per edge:
  - Correct: every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Overflow detect: if the corrected top digit has bit 3 set, set the sticky overflow scratch, since that bit is shifted out.
  - Shift: scratch shifts left by one, taking in the binary MSB; the binary register shifts left.
  - Counter increments.
  - The INPUT_WIDTH-th shift occurs at edge E0+INPUT_WIDTH. On that edge:
    - Load data with the post-shift scratch, or with all 4'hF digits if overflow is set (including from this final shift).
    - Load the overflow output.
    - Go to DONE.
- DONE: done=1 for exactly this one cycle, then go to IDLE on the next edge.
- Timing summary:
  - done is high in the cycle after edge E0+INPUT_WIDTH.
  - busy is high from after E0 through the DONE cycle.
  - Minimum start-to-start spacing is INPUT_WIDTH+2 cycles.
- data and overflow change only on the final-shift edge or on reset. They are stable at all other times, including during SHIFT, so the display never shows intermediate values.
- start while busy (SHIFT or DONE) is ignored: no queueing, and the binary input is not re-sampled.
- start held continuously high: a new conversion begins on each IDLE cycle, i.e. every INPUT_WIDTH+2 cycles.
- resetN asserted mid-conversion: aborts immediately, all outputs go to their reset values, and no done pulse is produced.
- binary = 0 converts to data = 0, overflow = 0.
- If INPUT_WIDTH is small enough that overflow is impossible, the overflow logic still exists and simply never fires.

Test Plan:
1. Reset and idle:
   - Assert resetN=0 mid-SHIFT.
   - Required: busy=0, done=0, overflow=0, data=0 immediately (asynchronous). No done pulse after release.
   - With start=0 held, all outputs stay constant for 100 cycles.
2. Nominal conversion and latency:
   - Defaults; binary=12_345_678, start pulse at edge E0.
   - Required: data=32'h12345678, overflow=0, done high only in the cycle after edge E0+27, busy high for 28 cycles.
   - data held at the old value throughout SHIFT.
3. Boundaries:
   - binary=0 gives data=32'h00000000.
   - binary=99_999_999 gives data=32'h99999999, overflow=0.
   - binary=100_000_000 gives data=32'hFFFFFFFF, overflow=1.
   - A following conversion of 7 gives data=32'h00000007, overflow=0.
4. Handshake:
   - Pulse start again at cycles 3, 10 and in the DONE cycle, with binary changed to 555.
   - Required: ignored; the result reflects the originally captured value.
   - start held high continuously: done pulses every 29 cycles.
5. Alternate parameters:
   - NUM_DIGITS=4, INPUT_WIDTH=14.
   - 9999 gives 16'h9999, done after 14 shifts.
   - 10000 gives 16'hFFFF with overflow=1.
   - 16383 gives 16'hFFFF with overflow=1.
6. Randomised (1000 values within range): data must equal the reference decimal digit packing, with overflow=0.

Source files
------------

// File: rtl/binary_to_bcd_converter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_converter
// Description : Sequential double-dabble (shift-and-add-3) converter. Turns an
//               unsigned binary value into packed BCD digits for the
//               multiplexed seven-segment controller. It converts one bit
//               per clock and uses a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   INPUT_WIDTH : width of the binary input (1..32)
//   NUM_DIGITS  : number of BCD digits produced (1..8)
// Ports
//   clock    in   system clock; all logic is on the rising edge
//   resetN   in   asynchronous, active-low reset
//   start    in   conversion request; sampled only while idle
//   binary   in   unsigned value; captured on the edge that accepts start
//   busy     out  high while a conversion is in progress (SHIFT or DONE)
//   done     out  one-cycle pulse; data/overflow have just been updated
//   overflow out  the last conversion exceeded 10^NUM_DIGITS - 1
//   data     out  packed BCD; digit 0 is bits [3:0] (least significant)
// ============================================================================
module binary_to_bcd_converter #(
    parameter int INPUT_WIDTH = 27,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      start,
    input  logic [INPUT_WIDTH-1:0]    binary,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [NUM_DIGITS*4-1:0]   data
);

    localparam int c_bcd_w = NUM_DIGITS * 4;
    // The counter only has to reach INPUT_WIDTH-1. A 1-bit input still
    // needs a 1-bit counter.
    localparam int c_cnt_w = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(INPUT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_accept;
    logic                     w_last_shift;

    logic [INPUT_WIDTH-1:0]   r_bin;
    logic [c_bcd_w-1:0]       r_bcd;
    logic                     r_ovf_sticky;
    logic [c_cnt_w-1:0]       r_cnt;

    logic [c_bcd_w-1:0]       w_corr;
    logic [c_bcd_w-1:0]       w_bcd_shifted;
    logic [INPUT_WIDTH-1:0]   w_bin_shifted;
    logic                     w_ovf_total;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last_shift = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_last_cnt) begin
                    w_last_shift = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen here is ignored on purpose; the host has to
                // wait for idle.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Add-3 correction. Each digit is corrected on its own, and no carry
    // passes between digits. A digit >= 5 would become >= 10 after the
    // shift, so adding 3 first makes the shift carry into the next digit.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign w_corr[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5)
                                  ? (r_bcd[i*4 +: 4] + 4'd3)
                                  : r_bcd[i*4 +: 4];
    end

    // After correction, bit 3 of the top digit is the bit about to leave
    // the scratch. Any 1 there means the value cannot be shown in
    // NUM_DIGITS digits.
    assign w_ovf_total   = r_ovf_sticky | w_corr[c_bcd_w-1];
    assign w_bcd_shifted = {w_corr[c_bcd_w-2:0], r_bin[INPUT_WIDTH-1]};
    assign w_bin_shifted = r_bin << 1;

    // ------------------------------------------------------------------
    // Datapath. The scratch registers run every SHIFT cycle. The visible
    // outputs load only on the final shift, so the display never shows a
    // partial result.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_bin        <= '0;
            r_bcd        <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= '0;
            data         <= '0;
            overflow     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bin        <= binary;
                r_bcd        <= '0;
                r_ovf_sticky <= 1'b0;
                r_cnt        <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bin        <= w_bin_shifted;
                r_bcd        <= w_bcd_shifted;
                r_ovf_sticky <= w_ovf_total;
                r_cnt        <= r_cnt + c_cnt_w'(1);
                if (w_last_shift) begin
                    // On overflow, load all 4'hF digits so the display
                    // shows a blank/error pattern instead of wrong digits.
                    data     <= w_ovf_total ? {c_bcd_w{1'b1}} : w_bcd_shifted;
                    overflow <= w_ovf_total;
                end
            end
        end
    end

    // Both outputs are decoded from the state register. An asynchronous
    // reset therefore clears them at once, with no extra flops.
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire
